// File: rtl/bbox_tracker_if.sv
// Sample/result bundle for the bounding-box tracker.
// The slave side is the tracker: it consumes pixel samples and frame
// markers and drives the published box, centre, count and flags.
interface bbox_tracker_if;
   logic [10:0] x_in;
   logic [9:0]  y_in;
   logic        valid_in;
   logic        mask_in;
   logic        new_frame_in;
   logic [11:0] xmin_out;
   logic [10:0] ymin_out;
   logic [11:0] xmax_out;
   logic [10:0] ymax_out;
   logic [11:0] xc_out;
   logic [10:0] yc_out;
   logic [20:0] count_out;
   logic        found_out;
   logic        valid_out;

   modport master (
      output x_in, y_in, valid_in, mask_in, new_frame_in,
      input  xmin_out, ymin_out, xmax_out, ymax_out, xc_out, yc_out,
             count_out, found_out, valid_out
   );

   modport slave (
      input  x_in, y_in, valid_in, mask_in, new_frame_in,
      output xmin_out, ymin_out, xmax_out, ymax_out, xc_out, yc_out,
             count_out, found_out, valid_out
   );
endinterface

// File: rtl/bbox_tracker.sv
// Per-frame bounding box / centre extractor for a 1-bit object mask.
// Masked pixels are folded into running min/max/count accumulators; at each
// frame marker the finished frame is published (detection or miss) and the
// accumulators restart. After MISS_LIMIT consecutive misses the box clears.
module bbox_tracker #(
   parameter int H_ACTIVE   = 1280,
   parameter int V_ACTIVE   = 720,
   parameter int MIN_PIXELS = 16,
   parameter int MISS_LIMIT = 4
) (
   input  logic           clk_in,
   input  logic           rst_in,
   bbox_tracker_if.slave  bus
);

   localparam logic [11:0] H_LIM     = 12'(H_ACTIVE);
   localparam logic [10:0] V_LIM     = 11'(V_ACTIVE);
   localparam logic [10:0] XMIN_INIT = 11'(H_ACTIVE - 1);
   localparam logic [9:0]  YMIN_INIT = 10'(V_ACTIVE - 1);
   localparam logic [20:0] CNT_MAX   = {21{1'b1}};
   localparam logic [20:0] MIN_PIX   = 21'(MIN_PIXELS);
   localparam logic [3:0]  MISS_LIM  = 4'(MISS_LIMIT);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   state_t      r_state, w_state_nxt;

   // running accumulators of the frame in progress
   logic [10:0] r_xmin, r_xmax, w_xmin_nxt, w_xmax_nxt;
   logic [9:0]  r_ymin, r_ymax, w_ymin_nxt, w_ymax_nxt;
   logic [20:0] r_cnt, w_cnt_nxt;
   logic [3:0]  r_miss, w_miss_nxt, w_miss_inc;

   // registered published outputs
   logic [11:0] r_xmin_o, r_xmax_o, r_xc_o, w_xmin_o, w_xmax_o, w_xc_o;
   logic [10:0] r_ymin_o, r_ymax_o, r_yc_o, w_ymin_o, w_ymax_o, w_yc_o;
   logic [20:0] r_count_o, w_count_o;
   logic        r_found_o, w_found_o;
   logic        r_valid_o, w_valid_o;

   logic        w_hit;
   logic        w_publish;
   logic        w_detect;
   logic [12:0] w_xsum;
   logic [11:0] w_ysum;

   assign w_hit = bus.valid_in && bus.mask_in &&
                  ({1'b0, bus.x_in} < H_LIM) && ({1'b0, bus.y_in} < V_LIM);
   assign w_publish = (r_state == ST_ACCUM) && bus.new_frame_in;
   assign w_detect  = (r_cnt >= MIN_PIX);
   // wide sums so the midpoint never overflows and stays inside the box
   assign w_xsum    = {2'b00, r_xmin} + {2'b00, r_xmax};
   assign w_ysum    = {2'b00, r_ymin} + {2'b00, r_ymax};
   assign w_miss_inc = (r_miss >= MISS_LIM) ? r_miss : (r_miss + 4'd1);

   // next-state logic: first frame marker arms accumulation, then stay there
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.new_frame_in) begin
               w_state_nxt = ST_ACCUM;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ACCUM: w_state_nxt = ST_ACCUM;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // accumulator update: restart (seeded by a same-cycle hit) on frame marker
   always_comb begin
      w_xmin_nxt = r_xmin;
      w_xmax_nxt = r_xmax;
      w_ymin_nxt = r_ymin;
      w_ymax_nxt = r_ymax;
      w_cnt_nxt  = r_cnt;
      if (bus.new_frame_in) begin
         if (w_hit) begin
            w_xmin_nxt = bus.x_in;
            w_xmax_nxt = bus.x_in;
            w_ymin_nxt = bus.y_in;
            w_ymax_nxt = bus.y_in;
            w_cnt_nxt  = 21'd1;
         end else begin
            w_xmin_nxt = XMIN_INIT;
            w_xmax_nxt = 11'd0;
            w_ymin_nxt = YMIN_INIT;
            w_ymax_nxt = 10'd0;
            w_cnt_nxt  = 21'd0;
         end
      end else if ((r_state == ST_ACCUM) && w_hit) begin
         w_xmin_nxt = (bus.x_in < r_xmin) ? bus.x_in : r_xmin;
         w_xmax_nxt = (bus.x_in > r_xmax) ? bus.x_in : r_xmax;
         w_ymin_nxt = (bus.y_in < r_ymin) ? bus.y_in : r_ymin;
         w_ymax_nxt = (bus.y_in > r_ymax) ? bus.y_in : r_ymax;
         w_cnt_nxt  = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + 21'd1);
      end else begin
         w_cnt_nxt  = r_cnt;
      end
   end

   // publish decision: load on detection, hold or clear on miss
   always_comb begin
      w_xmin_o   = r_xmin_o;
      w_xmax_o   = r_xmax_o;
      w_ymin_o   = r_ymin_o;
      w_ymax_o   = r_ymax_o;
      w_xc_o     = r_xc_o;
      w_yc_o     = r_yc_o;
      w_count_o  = r_count_o;
      w_found_o  = r_found_o;
      w_miss_nxt = r_miss;
      w_valid_o  = 1'b0;
      if (w_publish) begin
         w_valid_o = 1'b1;
         w_count_o = r_cnt;
         if (w_detect) begin
            w_xmin_o   = {1'b0, r_xmin};
            w_xmax_o   = {1'b0, r_xmax};
            w_ymin_o   = {1'b0, r_ymin};
            w_ymax_o   = {1'b0, r_ymax};
            w_xc_o     = 12'(w_xsum >> 1);
            w_yc_o     = 11'(w_ysum >> 1);
            w_found_o  = 1'b1;
            w_miss_nxt = 4'd0;
         end else begin
            w_miss_nxt = w_miss_inc;
            if (w_miss_inc == MISS_LIM) begin
               w_xmin_o  = 12'd0;
               w_xmax_o  = 12'd0;
               w_ymin_o  = 11'd0;
               w_ymax_o  = 11'd0;
               w_xc_o    = 12'd0;
               w_yc_o    = 11'd0;
               w_found_o = 1'b0;
            end else begin
               w_found_o = r_found_o;
            end
         end
      end else begin
         w_valid_o = 1'b0;
      end
   end

   // state, accumulator and output registers with synchronous reset
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state   <= ST_IDLE;
         r_xmin    <= XMIN_INIT;
         r_xmax    <= 11'd0;
         r_ymin    <= YMIN_INIT;
         r_ymax    <= 10'd0;
         r_cnt     <= 21'd0;
         r_miss    <= 4'd0;
         r_xmin_o  <= 12'd0;
         r_xmax_o  <= 12'd0;
         r_ymin_o  <= 11'd0;
         r_ymax_o  <= 11'd0;
         r_xc_o    <= 12'd0;
         r_yc_o    <= 11'd0;
         r_count_o <= 21'd0;
         r_found_o <= 1'b0;
         r_valid_o <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_xmin    <= w_xmin_nxt;
         r_xmax    <= w_xmax_nxt;
         r_ymin    <= w_ymin_nxt;
         r_ymax    <= w_ymax_nxt;
         r_cnt     <= w_cnt_nxt;
         r_miss    <= w_miss_nxt;
         r_xmin_o  <= w_xmin_o;
         r_xmax_o  <= w_xmax_o;
         r_ymin_o  <= w_ymin_o;
         r_ymax_o  <= w_ymax_o;
         r_xc_o    <= w_xc_o;
         r_yc_o    <= w_yc_o;
         r_count_o <= w_count_o;
         r_found_o <= w_found_o;
         r_valid_o <= w_valid_o;
      end
   end

   assign bus.xmin_out  = r_xmin_o;
   assign bus.xmax_out  = r_xmax_o;
   assign bus.ymin_out  = r_ymin_o;
   assign bus.ymax_out  = r_ymax_o;
   assign bus.xc_out    = r_xc_o;
   assign bus.yc_out    = r_yc_o;
   assign bus.count_out = r_count_o;
   assign bus.found_out = r_found_o;
   assign bus.valid_out = r_valid_o;

endmodule
